// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time on a word-organised RAM; response pulse LATENCY+1 cycles after accept.
// Backpressure: req_ready is low from the accept edge until the response cycle has completed.
module dmem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_bhw,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [2:0]    bhw_q, bhw_d;
   logic [AW+1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          err_q, err_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          rerr_q, rerr_d;

   logic [31:0]   mem [DEPTH];

   logic          bhw_ok, align_ok, range_ok;
   logic [AW-1:0] idx;
   logic [31:0]   rword, load_v, wword;
   logic [7:0]    byte_v;
   logic [15:0]   half_v;
   logic [3:0]    be;
   logic          ram_we;

   // Legality is decided on the live request so only the error flag needs storing.
   always_comb begin
      bhw_ok   = 1'b0;
      align_ok = 1'b1;
      unique case (req_bhw)
         3'b000, 3'b100: bhw_ok = 1'b1;
         3'b001, 3'b101: begin bhw_ok = 1'b1; align_ok = ~req_addr[0]; end
         3'b010:         begin bhw_ok = 1'b1; align_ok = (req_addr[1:0] == 2'b00); end
         default:        bhw_ok = 1'b0;
      endcase
      range_ok = (req_addr[31:AW+2] == '0);
   end

   assign idx    = addr_q[AW+1:2];
   assign rword  = mem[idx];
   assign byte_v = 8'(rword >> {addr_q[1:0], 3'b000});
   assign half_v = 16'(rword >> {addr_q[1], 4'b0000});

   always_comb begin
      unique case (bhw_q[1:0])
         2'b00: begin
            load_v = {{24{~bhw_q[2] & byte_v[7]}}, byte_v};
            be     = 4'b0001 << addr_q[1:0];
            wword  = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            load_v = {{16{~bhw_q[2] & half_v[15]}}, half_v};
            be     = addr_q[1] ? 4'b1100 : 4'b0011;
            wword  = {2{wdata_q[15:0]}};
         end
         default: begin
            load_v = rword;
            be     = 4'b1111;
            wword  = wdata_q;
         end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      bhw_d     = bhw_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      rerr_d    = rerr_q;
      ram_we    = 1'b0;
      req_ready = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d    = req_we;
               bhw_d   = req_bhw;
               addr_d  = req_addr[AW+1:0];
               wdata_d = req_wdata;
               err_d   = ~(bhw_ok & align_ok & range_ok);
               cnt_d   = 4'(LATENCY - 1);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               ram_we  = we_q & ~err_q;
               rerr_d  = err_q;
               rdata_d = (err_q | we_q) ? 32'd0 : load_v;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         bhw_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         bhw_q   <= bhw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         rerr_q  <= rerr_d;
      end
   end

   // RAM has no reset; ram_we is gated by state_q, which reset forces to IDLE.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
         end
      end
   end

   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = rerr_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder against a byte-array memory model with a timed expectation queue.
module tb_dmem_responder;
   localparam int DEPTH = 64;
   localparam int LAT   = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_bhw = 3'b000;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_bhw(req_bhw), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   int cmp_n = 0;
   int fail_n = 0;
   int cyc = 0;
   int pulses = 0;
   int accepts = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] mm [DEPTH*4];

   typedef struct {
      logic        we;
      logic [2:0]  bhw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          due;
      logic        lit_en;
      logic [31:0] lit_rd;
      logic        lit_err;
   } txn_t;
   txn_t q[$];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_n++;
      if (act !== exp) begin
         fail_n++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic int size_of(input logic [2:0] bhw);
      return (bhw[1:0] == 2'b00) ? 1 : (bhw[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic void model(input logic we, input logic [2:0] bhw, input logic [31:0] addr,
                                 output logic [31:0] rd, output logic err);
      int sz = size_of(bhw);
      logic legal = (bhw == 3'd0 || bhw == 3'd1 || bhw == 3'd2 || bhw == 3'd4 || bhw == 3'd5);
      logic [31:0] v = 32'd0;
      err = !legal || ((addr & 32'(sz - 1)) != 0) || ((addr >> 2) >= 32'(DEPTH));
      rd = 32'd0;
      if (!err && !we) begin
         for (int i = 0; i < sz; i++) v = v | (32'(mm[addr + i]) << (8 * i));
         if (!bhw[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
         rd = v;
      end
   endfunction

   function automatic void commit(input txn_t t);
      if (t.we && !t.exp_err)
         for (int i = 0; i < size_of(t.bhw); i++) mm[t.addr + i] = t.wdata[8*i +: 8];
   endfunction

   // Single compare process: every cycle out of reset, ready and the response are checked.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (rsp_valid) pulses++;
            chk("req_ready", 32'(req_ready), 32'(q.size() == 0));
            if (q.size() > 0 && cyc == q[0].due) begin
               chk("rsp_valid", 32'(rsp_valid), 32'd1);
               chk("rsp_rdata", rsp_rdata, q[0].exp_rd);
               chk("rsp_err", 32'(rsp_err), 32'(q[0].exp_err));
               if (q[0].lit_en) begin
                  chk("lit_rdata", rsp_rdata, q[0].lit_rd);
                  chk("lit_err", 32'(rsp_err), 32'(q[0].lit_err));
               end
               commit(q[0]);
               void'(q.pop_front());
            end else begin
               chk("rsp_valid", 32'(rsp_valid), 32'd0);
            end
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after the accept edge.
   task automatic send(input logic we, input logic [2:0] bhw, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic keep, input logic lit_en,
                       input logic [31:0] lit_rd, input logic lit_err);
      txn_t t;
      int   acc;
      bit   got = 0;
      req_we = we; req_bhw = bhw; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (req_ready) begin got = 1; break; end
         @(negedge clk);
      end
      if (!got) begin
         cmp_n++; fail_n++;
         $display("FAIL accept_timeout: req_ready stayed 0 for 50 cycles, expected 1");
         req_valid = 1'b0;
         return;
      end
      acc = cyc;
      t.we = we; t.bhw = bhw; t.addr = addr; t.wdata = wdata;
      model(we, bhw, addr, t.exp_rd, t.exp_err);
      t.due = acc + LAT + 1;
      t.lit_en = lit_en; t.lit_rd = lit_rd; t.lit_err = lit_err;
      @(posedge clk);
      q.push_back(t);
      accepts++;
      @(negedge clk);
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic lit(input logic we, input logic [2:0] bhw, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rd, input logic err);
      send(we, bhw, addr, wdata, 1'b0, 1'b1, rd, err);
      idle(LAT + 2);
   endtask

   initial begin
      int p0, a0;
      #1;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int w = 0; w < DEPTH; w++)
         send(1'b1, 3'b010, 32'(w * 4), $urandom, 1'b1, 1'b0, 32'd0, 1'b0);
      idle(LAT + 2);

      lit(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
      lit(1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
      lit(1'b1, 3'b010, 32'h10, 32'h11223344, 32'd0, 1'b0);
      lit(1'b1, 3'b000, 32'h13, 32'h00000080, 32'd0, 1'b0);
      lit(1'b0, 3'b010, 32'h10, 32'd0, 32'h80223344, 1'b0);
      lit(1'b0, 3'b000, 32'h13, 32'd0, 32'hFFFFFF80, 1'b0);
      lit(1'b0, 3'b100, 32'h13, 32'd0, 32'h00000080, 1'b0);
      lit(1'b1, 3'b010, 32'h20, 32'h12345678, 32'd0, 1'b0);
      lit(1'b1, 3'b001, 32'h22, 32'h0000ABCD, 32'd0, 1'b0);
      lit(1'b0, 3'b001, 32'h22, 32'd0, 32'hFFFFABCD, 1'b0);
      lit(1'b0, 3'b101, 32'h22, 32'd0, 32'h0000ABCD, 1'b0);
      lit(1'b0, 3'b010, 32'h20, 32'd0, 32'hABCD5678, 1'b0);
      lit(1'b0, 3'b010, 32'h12, 32'd0, 32'd0, 1'b1);
      lit(1'b1, 3'b001, 32'h21, 32'h00001111, 32'd0, 1'b1);
      lit(1'b0, 3'b010, 32'h20, 32'd0, 32'hABCD5678, 1'b0);
      lit(1'b0, 3'b011, 32'h20, 32'd0, 32'd0, 1'b1);
      lit(1'b0, 3'b010, 32'(DEPTH * 4), 32'd0, 32'd0, 1'b1);

      p0 = pulses; a0 = accepts;
      send(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 1'b1, 1'b0, 32'd0, 1'b0);
      send(1'b0, 3'b010, 32'h40, 32'd0, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0);
      send(1'b0, 3'b100, 32'h41, 32'd0, 1'b0, 1'b1, 32'h000000F0, 1'b0);
      idle(LAT + 4);
      chk("b2b_pulses", 32'(pulses - p0), 32'd3);
      chk("b2b_accepts", 32'(accepts - a0), 32'd3);

      lit(1'b1, 3'b010, 32'h30, 32'hA5A5A5A5, 32'd0, 1'b0);
      lit(1'b0, 3'b010, 32'h30, 32'd0, 32'hA5A5A5A5, 1'b0);
      send(1'b1, 3'b010, 32'h30, 32'h00000055, 1'b0, 1'b0, 32'd0, 1'b0);
      #2 rst_n = 1'b0;
      q.delete();
      #1;
      chk("arst_ready", 32'(req_ready), 32'd1);
      chk("arst_valid", 32'(rsp_valid), 32'd0);
      chk("arst_rdata", rsp_rdata, 32'd0);
      chk("arst_err", 32'(rsp_err), 32'd0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      idle(LAT + 4);
      lit(1'b0, 3'b010, 32'h30, 32'd0, 32'hA5A5A5A5, 1'b0);

      for (int n = 0; n < 300; n++) begin
         logic [2:0]  bhw;
         logic [31:0] addr;
         int          off, sel;
         sel = $urandom_range(0, 10);
         case (sel)
            0, 1:    bhw = 3'b000;
            2, 3:    bhw = 3'b001;
            4, 5, 6: bhw = 3'b010;
            7:       bhw = 3'b100;
            8, 9:    bhw = 3'b101;
            default: bhw = 3'($urandom_range(0, 2) == 0 ? 3 : $urandom_range(6, 7));
         endcase
         off = $urandom_range(0, 3);
         if ($urandom_range(0, 3) != 0) off = off & ~(size_of(bhw) - 1);
         if ($urandom_range(0, 15) == 0) addr = 32'(($urandom_range(DEPTH, DEPTH + 200) * 4) + off);
         else addr = 32'(($urandom_range(0, DEPTH - 1) * 4) + off);
         send(1'($urandom_range(0, 1)), bhw, addr, $urandom, 1'($urandom_range(0, 1)), 1'b0, 32'd0, 1'b0);
         if (!req_valid) idle($urandom_range(0, 2));
      end
      idle(LAT + 4);
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the data-memory request interface that the pipeline's memory functional unit drives.
- Accepts one load/store request at a time and performs the access on an internal word-organised RAM.
  - Stores: byte, half and word writes with byte lanes.
  - Loads: sign/zero extension.
- Returns a single-cycle response after a programmable latency.
- Sits between the memory FU and the data RAM; replaces the direct RAM instance so the FU can use a valid/ready handshake instead of a fixed cycle count.

Parameters:
- DEPTH, 1024, number of 32-bit words in the RAM; power of two.
- LATENCY, 2, cycles spent in WAIT state before the response; range 1..15.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, responder can accept a request this cycle.
- req_we, input, 1, 1 = store, 0 = load.
- req_bhw, input, 3, access type:
  - 000 = byte signed
  - 001 = half signed
  - 010 = word
  - 100 = byte unsigned
  - 101 = half unsigned
  - others = illegal.
- req_addr, input, 32, byte address.
- req_wdata, input, 32, store data, right-aligned.
- rsp_valid, output, 1, one-cycle response pulse.
- rsp_rdata, output, 32, extended load data; 0 for stores and errors.
- rsp_err, output, 1, valid with rsp_valid; request was misaligned, illegal, or out of range.

Behaviour:
- Reset (rst_n = 0, async):
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latency counter = 0.
  - RAM contents are not reset.
- Handshake: a request is accepted on a clock edge where req_valid & req_ready.
  - All request fields are captured into registers at acceptance.
  - Inputs are ignored at other times.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. On accept:
    - capture the request and check legality;
    - counter = LATENCY - 1;
    - go to WAIT.
  - WAIT: req_ready = 0.
    - When counter = 0, perform the RAM access and go to RESP.
    - Otherwise decrement the counter.
  - RESP: rsp_valid = 1 for exactly one cycle, with rsp_rdata/rsp_err; req_ready = 0; next state IDLE.
  - Accept-to-rsp_valid latency = LATENCY + 1 cycles.
  - Back-to-back requests are possible: the next accept can occur in the cycle after RESP, so throughput is one request per LATENCY + 2 cycles.
- Legality (error => no RAM write; rsp_rdata = 0; rsp_err = 1):
  - req_bhw not in {000, 001, 010, 100, 101};
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 00;
  - word index addr[31:2] >= DEPTH.
- Store:
  - Byte: writes wdata[7:0] to lane addr[1:0].
  - Half: writes wdata[15:0] to lanes {addr[1], 0} and {addr[1], 1}.
  - Word: writes all 4 lanes.
  - Other lanes are unchanged.
  - The write commits at the WAIT-to-RESP edge.
  - rsp_rdata = 0, rsp_err = 0.
- Load:
  - Select the byte/half from the lane given by addr[1:0].
  - Signed types sign-extend from bit 7/15; unsigned types zero-extend.
- Little-endian byte order: lane 0 = bits 7:0.
- Reset mid-operation (asserted in WAIT or RESP): an un-committed store does not write, and no response is produced after release.
- req_valid deasserting while req_ready = 0 has no effect.

Test Plan:
- Reset then word store/load:
  - store bhw = 010, addr 0x10, wdata 0xDEADBEEF; then load bhw = 010 at 0x10.
  - Load response rsp_rdata = 0xDEADBEEF, rsp_err = 0.
  - rsp_valid rises exactly LATENCY + 1 cycles after accept.
- Byte store and signed/unsigned load:
  - store bhw = 000, addr 0x13, wdata 0x00000080 over word 0x11223344 at 0x10.
  - Word load at 0x10 returns 0x80223344.
  - lb at 0x13 returns 0xFFFFFF80; lbu at 0x13 returns 0x00000080.
- Half access:
  - store bhw = 001, addr 0x22, wdata 0x0000ABCD.
  - lh at 0x22 returns 0xFFFFABCD; lhu returns 0x0000ABCD; word at 0x20 has [15:0] unchanged.
- Errors:
  - lw at 0x12 -> rsp_err = 1, rsp_rdata = 0.
  - sh at 0x21 -> rsp_err = 1; a following lw at 0x20 is unchanged.
  - bhw = 011 -> rsp_err = 1.
  - addr = DEPTH*4 -> rsp_err = 1.
- Handshake:
  - hold req_valid high continuously with 3 different requests.
  - Exactly 3 accepts and 3 rsp_valid pulses, each pulse one cycle wide.
  - req_ready is low from accept through RESP.
- Async reset:
  - assert rst_n = 0 mid-WAIT of a store of 0x55 to 0x30.
  - Outputs go to reset values immediately (before the next edge).
  - No rsp_valid after release; lw at 0x30 returns the old value.
